// File: rtl/frame_stream_ctrl.sv
// Frame streaming sequencer: source RAM -> prefetch FIFO -> pixel core (or bypass) -> destination RAM.
// Frame length, mode and counters are latched on start; the frame length is clamped to DEPTH.
module frame_stream_ctrl #(
   parameter int DW     = 8,
   parameter int DEPTH  = 76800,
   parameter int AW     = 17,
   parameter int FIFO_D = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          bypass_i,
   input  logic [AW-1:0] frame_len_i,
   input  logic          abort_i,
   output logic          src_en_o,
   output logic [AW-1:0] src_addr_o,
   input  logic [DW-1:0] src_data_i,
   output logic          core_valid_o,
   output logic [DW-1:0] core_data_o,
   input  logic          core_ready_i,
   input  logic          res_valid_i,
   input  logic [DW-1:0] res_data_i,
   output logic          res_ready_o,
   output logic          dst_en_o,
   output logic          dst_we_o,
   output logic [AW-1:0] dst_addr_o,
   output logic [DW-1:0] dst_data_o,
   output logic          busy_o,
   output logic          done_o,
   output logic [AW-1:0] wr_count_o
);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(FIFO_D);
   localparam int OW = $clog2(FIFO_D + 1);
   localparam int LW = OW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   len_q, len_d;
   logic [CW-1:0]   rdCount_q, rdCount_d;
   logic [CW-1:0]   wrCount_q, wrCount_d;
   logic            bypass_q, bypass_d;
   logic            inflight_q, inflight_d;
   logic [DW-1:0]   fifoMem_q [FIFO_D];
   logic [PW-1:0]   wptr_q, rptr_q;
   logic [OW-1:0]   occ_q;

   logic            run, fifoValid, coreValid, resReady;
   logic            push, pop, rdEn, wrEn;
   logic [DW-1:0]   head, wrData;
   logic [LW-1:0]   level;
   logic [CW-1:0]   startLen;

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
   endfunction

   // Datapath steering; a read is only issued if its data is guaranteed a FIFO slot on arrival.
   always_comb begin
      run       = (state_q == RUN);
      fifoValid = (occ_q != '0);
      head      = fifoMem_q[rptr_q];
      coreValid = run && !bypass_q && fifoValid;
      resReady  = run && !bypass_q && (wrCount_q < len_q);
      if (bypass_q) begin
         pop    = run && fifoValid && (wrCount_q < len_q);
         wrEn   = pop;
         wrData = head;
      end else begin
         pop    = coreValid && core_ready_i;
         wrEn   = res_valid_i && resReady;
         wrData = res_data_i;
      end
      level = LW'(occ_q) - LW'(pop) + LW'(inflight_q);
      rdEn  = run && (rdCount_q < len_q) && (level < LW'(FIFO_D));
      push  = run && inflight_q && !abort_i;
   end

   // Next state uses the post-write count so done_o lands the cycle after the final write.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      bypass_d   = bypass_q;
      rdCount_d  = rdCount_q;
      wrCount_d  = wrCount_q;
      inflight_d = rdEn && !abort_i;
      startLen   = (CW'(frame_len_i) > CW'(DEPTH)) ? CW'(DEPTH) : CW'(frame_len_i);
      case (state_q)
         IDLE: begin
            if (start_i) begin
               len_d     = startLen;
               bypass_d  = bypass_i;
               rdCount_d = '0;
               wrCount_d = '0;
               state_d   = (startLen == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            rdCount_d = rdCount_q + CW'(rdEn);
            wrCount_d = wrCount_q + CW'(wrEn);
            if (abort_i) begin
               state_d = IDLE;
            end else if (wrCount_d == len_q) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         len_q      <= '0;
         bypass_q   <= 1'b0;
         rdCount_q  <= '0;
         wrCount_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         bypass_q   <= bypass_d;
         rdCount_q  <= rdCount_d;
         wrCount_q  <= wrCount_d;
         inflight_q <= inflight_d;
      end
   end

   // Prefetch FIFO; an abort flushes it so stale pixels never leak into the next frame.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
         for (int i = 0; i < FIFO_D; i++) begin
            fifoMem_q[i] <= '0;
         end
      end else if (run && abort_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
      end else begin
         if (push) begin
            fifoMem_q[wptr_q] <= src_data_i;
            wptr_q            <= nextPtr(wptr_q);
         end
         if (pop) begin
            rptr_q <= nextPtr(rptr_q);
         end
         occ_q <= occ_q + OW'(push) - OW'(pop);
      end
   end

   assign src_en_o     = rdEn;
   assign src_addr_o   = rdCount_q[AW-1:0];
   assign core_valid_o = coreValid;
   assign core_data_o  = coreValid ? head : '0;
   assign res_ready_o  = resReady;
   assign dst_en_o     = wrEn;
   assign dst_we_o     = wrEn;
   assign dst_addr_o   = wrCount_q[AW-1:0];
   assign dst_data_o   = wrEn ? wrData : '0;
   assign busy_o       = run;
   assign done_o       = (state_q == DONE);
   assign wr_count_o   = wrCount_q[AW-1:0];

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Self-checking bench for frame_stream_ctrl: RAM and inverting-core models, a table of frames,
// plus back-pressure, abort and mid-frame reset sequences.
module tb_frame_stream_ctrl;
   localparam int DW    = 8;
   localparam int DEPTH = 300;
   localparam int AW    = 10;
   localparam int FD    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, bypass, abort;
   logic [AW-1:0] frameLen;
   logic          srcEn;
   logic [AW-1:0] srcAddr;
   logic [DW-1:0] srcData = '0;
   logic          coreValid, coreReady;
   logic [DW-1:0] coreData;
   logic          resValid, resReady;
   logic [DW-1:0] resData;
   logic          dstEn, dstWe;
   logic [AW-1:0] dstAddr;
   logic [DW-1:0] dstData;
   logic          busy, done;
   logic [AW-1:0] wrCount;

   frame_stream_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .FIFO_D(FD)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .bypass_i(bypass), .frame_len_i(frameLen),
      .abort_i(abort), .src_en_o(srcEn), .src_addr_o(srcAddr), .src_data_i(srcData),
      .core_valid_o(coreValid), .core_data_o(coreData), .core_ready_i(coreReady),
      .res_valid_i(resValid), .res_data_i(resData), .res_ready_o(resReady),
      .dst_en_o(dstEn), .dst_we_o(dstWe), .dst_addr_o(dstAddr), .dst_data_o(dstData),
      .busy_o(busy), .done_o(done), .wr_count_o(wrCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      int len;
      bit byp;
      bit stall;
      int pattern;
      int expWrites;
      int expDone;
   } vec_t;

   logic [DW-1:0] srcMem [1024];
   logic [DW-1:0] dstMem [1024];
   logic [DW-1:0] coreQ [$];

   int  checks = 0, errors = 0;
   int  cyc = 0, startCyc = 0;
   int  nWrites, nDone, doneCyc, firstAct, firstRd, lastWr;
   int  srcEnCount, consumed, maxLevel, orderErr, busyErr;
   bit  curBypass = 1'b0, stallEn = 1'b0, validGate = 1'b1;
   int  readyHold = 0, validHold = 0, bpFrom = 0, bpTo = 0;

   // Source RAM: registered read, data valid the cycle after the enable.
   always @(posedge clk) begin
      if (srcEn) srcData <= srcMem[srcAddr];
   end

   // Edge monitor: logs handshakes, destination writes and done pulses in frame-relative cycles.
   always @(posedge clk) begin
      if (!rst) begin
         if (srcEn) begin
            srcEnCount++;
            if (firstRd < 0) firstRd = cyc - startCyc;
         end
         if (!curBypass && coreValid && firstAct < 0) firstAct = cyc - startCyc;
         if (coreValid && coreReady) begin
            coreQ.push_back(8'(255 - coreData));
            consumed++;
         end
         if (dstEn && dstWe) begin
            if (int'(dstAddr) != nWrites) orderErr++;
            dstMem[dstAddr] = dstData;
            nWrites++;
            lastWr = cyc - startCyc;
            if (curBypass) begin
               consumed++;
               if (firstAct < 0) firstAct = cyc - startCyc;
            end
         end
         if (resValid && resReady) void'(coreQ.pop_front());
         if (done) begin
            nDone++;
            doneCyc = cyc - startCyc;
            if (busy) busyErr++;
         end
         if (srcEnCount - consumed > maxLevel) maxLevel = srcEnCount - consumed;
      end
      cyc++;
   end

   // Core model drive: stall runs of 1-5 cycles on ready and on result valid, plus a forced ready-low window.
   always @(negedge clk) begin
      int rel;
      rel = cyc - startCyc;
      if (stallEn) begin
         if (readyHold > 0) begin
            coreReady = 1'b0;
            readyHold--;
         end else begin
            coreReady = 1'b1;
            if ($urandom_range(0, 3) == 0) readyHold = $urandom_range(1, 5);
         end
         if (validHold > 0) begin
            validGate = 1'b0;
            validHold--;
         end else begin
            validGate = 1'b1;
            if ($urandom_range(0, 3) == 0) validHold = $urandom_range(1, 5);
         end
      end else begin
         coreReady = 1'b1;
         validGate = 1'b1;
      end
      if (rel >= bpFrom && rel < bpTo) coreReady = 1'b0;
      resValid = validGate && (coreQ.size() != 0);
      resData  = (coreQ.size() != 0) ? coreQ[0] : 8'h00;
   end

   task automatic checkOutput(string name, longint actual, longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   function automatic longint outVec();
      logic [63:0] v;
      v = 64'({srcEn, srcAddr, coreValid, coreData, resReady, dstEn, dstWe,
               dstAddr, dstData, busy, done, wrCount});
      return longint'(v);
   endfunction

   function automatic int refClamp(int len);
      return (len > DEPTH) ? DEPTH : len;
   endfunction

   task automatic prepFrame(int pattern);
      nWrites = 0; nDone = 0; doneCyc = -1; firstAct = -1; firstRd = -1; lastWr = -1;
      srcEnCount = 0; consumed = 0; maxLevel = 0; orderErr = 0; busyErr = 0;
      coreQ.delete();
      for (int i = 0; i < 1024; i++) begin
         srcMem[i] = (pattern == 0) ? 8'(i) : 8'($urandom);
         dstMem[i] = 'x;
      end
   endtask

   task automatic launch(int len, bit byp);
      frameLen  = AW'(len);
      bypass    = byp;
      curBypass = byp;
      start     = 1'b1;
      startCyc  = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(string name, int budget);
      int n = 0;
      while (nDone == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (nDone == 0) checkOutput({name, " timeout"}, 0, 1);
      repeat (4) @(negedge clk);
   endtask

   task automatic checkFrame(string name, int n, bit byp);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         logic [DW-1:0] e;
         e = byp ? srcMem[i] : 8'(255 - srcMem[i]);
         if (dstMem[i] !== e) begin
            if (bad == 0) $display("[TB] first bad pixel %0d: got %h expected %h", i, dstMem[i], e);
            bad++;
         end
      end
      checkOutput({name, " bad pixels"}, bad, 0);
      checkOutput({name, " write order errs"}, orderErr, 0);
      checkOutput({name, " writes"}, nWrites, n);
   endtask

   task automatic applyStimulus(vec_t v, int idx);
      string nm;
      nm = $sformatf("v%0d", idx);
      prepFrame(v.pattern);
      stallEn = v.stall;
      launch(v.len, v.byp);
      waitDone(nm, 20000);
      checkFrame(nm, v.expWrites, v.byp);
      checkOutput({nm, " done pulses"}, nDone, 1);
      checkOutput({nm, " busy at done"}, busyErr, 0);
      checkOutput({nm, " wr_count_o"}, wrCount, v.expWrites);
      checkOutput({nm, " fifo bound held"}, maxLevel <= FD, 1);
      if (v.expDone >= 0) checkOutput({nm, " done cycle"}, doneCyc, v.expDone);
      if (v.len == 0) begin
         checkOutput({nm, " src enables"}, srcEnCount, 0);
      end else begin
         checkOutput({nm, " first read cycle"}, firstRd, 1);
         checkOutput({nm, " first pixel cycle"}, firstAct, 3);
         if (v.byp && v.expDone >= 0) checkOutput({nm, " last write cycle"}, lastWr, v.expDone - 1);
      end
      stallEn = 1'b0;
   endtask

   initial begin
      vec_t vecs[11];
      int snapW, snapR;

      vecs[0] = '{len: 16,   byp: 1, stall: 0, pattern: 0, expWrites: 16,  expDone: 19};
      vecs[1] = '{len: 0,    byp: 0, stall: 0, pattern: 1, expWrites: 0,   expDone: 1};
      vecs[2] = '{len: 0,    byp: 1, stall: 0, pattern: 1, expWrites: 0,   expDone: 1};
      vecs[3] = '{len: 1000, byp: 1, stall: 0, pattern: 1, expWrites: 300, expDone: 303};
      vecs[4] = '{len: 1000, byp: 0, stall: 1, pattern: 1, expWrites: 300, expDone: -1};
      vecs[5] = '{len: 300,  byp: 0, stall: 1, pattern: 1, expWrites: 300, expDone: -1};
      vecs[6] = '{len: 1,    byp: 1, stall: 0, pattern: 1, expWrites: 1,   expDone: 4};
      vecs[7] = '{len: 5,    byp: 0, stall: 0, pattern: 1, expWrites: 5,   expDone: -1};
      for (int i = 8; i < 11; i++) begin
         vecs[i].len       = $urandom_range(1, 1023);
         vecs[i].byp       = 1'($urandom_range(0, 1));
         vecs[i].stall     = 1'b1;
         vecs[i].pattern   = 1;
         vecs[i].expWrites = refClamp(vecs[i].len);
         vecs[i].expDone   = -1;
      end

      rst = 1'b1; start = 1'b0; bypass = 1'b0; abort = 1'b0; frameLen = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset outputs", outVec(), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

      // Back-pressure: ready held low in cycles 3..22; a start pulse mid-frame must be ignored.
      prepFrame(1);
      bpFrom = 3; bpTo = 23;
      launch(40, 1'b0);
      while (cyc < startCyc + 10) @(negedge clk);
      frameLen = AW'(5); bypass = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < startCyc + 22) @(negedge clk);
      checkOutput("bp reads while stalled", srcEnCount, FD);
      checkOutput("bp writes while stalled", nWrites, 0);
      checkOutput("bp core_valid held", coreValid, 1);
      waitDone("bp", 5000);
      bpFrom = 0; bpTo = 0;
      checkFrame("bp", 40, 1'b0);
      checkOutput("bp fifo filled", maxLevel, FD);
      checkOutput("bp done pulses", nDone, 1);

      // Abort after 10 writes: the write in the abort cycle still lands, then everything stops.
      prepFrame(1);
      launch(50, 1'b1);
      for (int n = 0; n < 200 && nWrites < 10; n++) @(negedge clk);
      snapW = nWrites;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      snapR = srcEnCount;
      checkOutput("abort busy low", busy, 0);
      repeat (6) @(negedge clk);
      checkOutput("abort writes", nWrites, snapW + 1);
      checkOutput("abort wr_count_o", wrCount, nWrites);
      checkOutput("abort no done", nDone, 0);
      checkOutput("abort reads stop", srcEnCount, snapR);
      prepFrame(1);
      stallEn = 1'b1;
      launch(8, 1'b0);
      waitDone("post abort", 2000);
      stallEn = 1'b0;
      checkFrame("post abort", 8, 1'b0);
      checkOutput("post abort done", nDone, 1);

      // Reset mid-frame: outputs clear without waiting for a clock edge, then a full frame runs.
      prepFrame(1);
      stallEn = 1'b1;
      launch(200, 1'b0);
      repeat (30) @(negedge clk);
      #2 rst = 1'b1;
      #1 checkOutput("mid-frame reset outputs", outVec(), 0);
      @(negedge clk);
      coreQ.delete();
      @(negedge clk);
      rst = 1'b0;
      prepFrame(1);
      launch(120, 1'b0);
      waitDone("post reset", 5000);
      stallEn = 1'b0;
      checkFrame("post reset", 120, 1'b0);
      checkOutput("post reset done", nDone, 1);
      checkOutput("post reset wr_count_o", wrCount, 120);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
